// File: rtl/core_pkg.sv
// Shared fetch-side types, widths and helpers for the single-cycle core.
package core_pkg;

  localparam int unsigned XLEN               = 32;
  localparam int unsigned INSTR_BYTES        = 4;
  localparam int unsigned IMEM_BYTES_DEFAULT = 128;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    HALT   = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_pkt_t;

  // A fetch address is usable only if word-aligned and inside the memory.
  function automatic logic addr_legal(logic [XLEN-1:0] addr, logic [XLEN-1:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, decode and execute.
interface inst_fetch_unit_if;
  import core_pkg::*;

  logic [XLEN-1:0] read_address;
  logic [XLEN-1:0] instruction_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            fault;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output read_address,
    input  instruction_in,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_target,
    output fault,
    output fetch_count
  );

  modport slave (
    input  read_address,
    output instruction_in,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_target,
    input  fault,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_pc_next.sv
// Next-pc selection and legality decision; redirect outranks sequential fetch.
module fetch_pc_next
  import core_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            run_i,
  input  logic            load_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_next_c,
  output logic            fetch_c,
  output logic            flush_c,
  output logic            fault_c
);

  localparam logic [XLEN-1:0] IMEM_LIMIT = XLEN'(IMEM_BYTES);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INSTR_BYTES);

  always_comb begin
    pc_next_c = pc_i;
    fetch_c   = 1'b0;
    flush_c   = 1'b0;
    fault_c   = 1'b0;
    if (run_i && redirect_valid_i) begin
      flush_c = 1'b1;
      if (addr_legal(redirect_target_i, IMEM_LIMIT)) begin
        pc_next_c = redirect_target_i;
      end else begin
        fault_c = 1'b1;
      end
    end else if (run_i && load_i) begin
      // Legality is judged on the pc about to be fetched, so running off the end faults.
      if (addr_legal(pc_i, IMEM_LIMIT)) begin
        fetch_c   = 1'b1;
        pc_next_c = pc_i + PC_STEP;
      end else begin
        fault_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch unit: owns the pc, registers one instruction for decode, handles redirects and faults.
module inst_fetch_unit
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  inst_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  fetch_pkt_t      stage_q, stage_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] count_q, count_d;

  logic            run;
  logic            load;
  logic            xfer;
  logic [XLEN-1:0] pc_next_c;
  logic            fetch_c;
  logic            flush_c;
  logic            fault_c;

  assign run  = (state_q == RUN);
  assign load = !valid_q || bus.out_ready;
  assign xfer = valid_q && bus.out_ready;

  fetch_pc_next #(
    .IMEM_BYTES (IMEM_BYTES)
  ) u_pc_next (
    .pc_i              (pc_q),
    .run_i             (run),
    .load_i            (load),
    .redirect_valid_i  (bus.redirect_valid),
    .redirect_target_i (bus.redirect_target),
    .pc_next_c         (pc_next_c),
    .fetch_c           (fetch_c),
    .flush_c           (flush_c),
    .fault_c           (fault_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WARMUP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: one warm-up cycle, then run until a fault.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WARMUP:  state_d = RUN;
      RUN:     if (fault_c) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = WARMUP;
    endcase
  end

  // Datapath next values per state.
  always_comb begin
    pc_d    = pc_q;
    stage_d = stage_q;
    valid_d = valid_q;
    fault_d = fault_q;
    count_d = count_q;
    if (xfer) begin
      count_d = count_q + XLEN'(1);
    end
    unique case (state_q)
      RUN: begin
        pc_d = pc_next_c;
        if (flush_c || fault_c) begin
          valid_d = 1'b0;
        end else if (fetch_c) begin
          valid_d       = 1'b1;
          stage_d.instr = bus.instruction_in;
          stage_d.pc    = pc_q;
        end
        if (fault_c) begin
          fault_d = 1'b1;
        end
      end
      HALT:    valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      stage_q <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      stage_q <= stage_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign bus.read_address = pc_q;
  assign bus.out_valid    = valid_q;
  assign bus.out_instr    = stage_q.instr;
  assign bus.out_pc       = stage_q.pc;
  assign bus.fault        = fault_q;
  assign bus.fetch_count  = count_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed, table-driven bench for inst_fetch_unit against a small word memory.
module tb_inst_fetch_unit;
  import core_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_BYTES (128)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [32];

  always_comb begin
    if (bus.read_address < 32'd128) bus.instruction_in = mem[bus.read_address[6:2]];
    else                            bus.instruction_in = 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        rv;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] era;
    logic        ef;
    logic [31:0] ec;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic r, logic rdy, logic rv, logic [31:0] t);
    rst                 = r;
    bus.out_ready       = rdy;
    bus.redirect_valid  = rv;
    bus.redirect_target = t;
  endtask

  task automatic check_all(string tag, logic ev, logic [31:0] epc, logic [31:0] einstr,
                           logic [31:0] era, logic ef, logic [31:0] ec);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(ev));
    check({tag, "_pc"},    bus.out_pc,         epc);
    check({tag, "_instr"}, bus.out_instr,      einstr);
    check({tag, "_raddr"}, bus.read_address,   era);
    check({tag, "_fault"}, 32'(bus.fault),     32'(ef));
    check({tag, "_count"}, bus.fetch_count,    ec);
  endtask

  task automatic add(logic r, logic rdy, logic rv, logic [31:0] t, logic ev, logic [31:0] epc,
                     logic [31:0] einstr, logic [31:0] era, logic ef, logic [31:0] ec);
    vec_t v;
    v.rst = r; v.ready = rdy; v.rv = rv; v.tgt = t;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.era = era; v.ef = ef; v.ec = ec;
    vecs.push_back(v);
  endtask

  function automatic logic [31:0] im(int unsigned a);
    return mem[a / 4];
  endfunction

  initial begin
    logic [31:0] last_pc;
    for (int i = 0; i < 32; i++) mem[i] = {8'hA5, 16'(i), 8'h13};
    mem[0]  = 32'h0000_0000;
    mem[1]  = 32'h0198_86B3;
    mem[11] = 32'h0094_8663;

    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    step();
    check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);

    // Startup, backpressure, branch, misaligned redirect, out-of-range redirect.
    add(0, 1, 0, 0,        0, 0,  0,            0,  0, 0);
    add(0, 1, 0, 0,        1, 0,  0,            4,  0, 0);
    add(0, 1, 0, 0,        1, 4,  32'h019886B3, 8,  0, 1);
    add(0, 1, 0, 0,        1, 8,  im(8),        12, 0, 2);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 1, 8, im(8), 12, 0, 2);
    for (int a = 12; a <= 44; a += 4) add(0, 1, 0, 0, 1, 32'(a), im(a), 32'(a + 4), 0, 32'(a / 4));
    add(0, 1, 1, 56,       0, 44, 32'h00948663, 56, 0, 12);
    add(0, 1, 0, 0,        1, 56, im(56),       60, 0, 12);
    add(0, 1, 0, 0,        1, 60, im(60),       64, 0, 13);
    add(0, 1, 1, 32'h22,   0, 60, im(60),       64, 1, 14);
    add(0, 1, 1, 8,        0, 60, im(60),       64, 1, 14);
    add(0, 1, 0, 0,        0, 60, im(60),       64, 1, 14);
    add(1, 1, 0, 0,        0, 0,  0,            0,  0, 0);
    add(0, 1, 1, 56,       0, 0,  0,            0,  0, 0);
    add(0, 1, 0, 0,        1, 0,  0,            4,  0, 0);
    add(0, 1, 1, 32'hC8,   0, 0,  0,            4,  1, 1);
    add(0, 1, 0, 0,        0, 0,  0,            4,  1, 1);
    add(1, 1, 0, 0,        0, 0,  0,            0,  0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ready, vecs[i].rv, vecs[i].tgt);
      step();
      check_all($sformatf("row%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                vecs[i].era, vecs[i].ef, vecs[i].ec);
    end

    // Sequential run off the end of memory.
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    drive(1'b0, 1'b1, 1'b1, 32'd116);
    step();
    check("runoff_redir_raddr", bus.read_address, 32'd116);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    last_pc = 32'hFFFF_FFFF;
    for (int c = 0; c < 40; c++) begin
      step();
      if (bus.out_valid) last_pc = bus.out_pc;
      if (bus.fault) break;
    end
    check("runoff_fault",   32'(bus.fault),     32'd1);
    check("runoff_last_pc", last_pc,            32'd124);
    check("runoff_valid",   32'(bus.out_valid), 32'd0);
    check("runoff_raddr",   bus.read_address,   32'd128);
    check("runoff_count",   bus.fetch_count,    32'd4);
    step();
    check("runoff_halt_raddr", bus.read_address,   32'd128);
    check("runoff_halt_valid", 32'(bus.out_valid), 32'd0);

    // Reset while stalled with a redirect on the same edge.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    step();
    drive(1'b0, 1'b1, 1'b1, 32'd8);
    step();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    step();
    check_all("stall", 1'b1, 32'd8, im(8), 32'd12, 1'b0, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'd56);
    step();
    check_all("rst_mid", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    step();
    check_all("rst_warm", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    step();
    check_all("rst_first", 1'b1, 32'h0, 32'h0, 32'd4, 1'b0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Fetch-side initiator for the single-cycle core's word instruction memory. Owns the PC and drives the byte read address to the memory; memory returns the instruction combinationally.
- Registers each fetched instruction with its PC into a one-entry output stage, delivered to decode over a valid/ready handshake.
- Accepts branch/jump redirects from execute. Halts with a fault flag on a misaligned or out-of-range PC.

Parameters:
- RESET_PC, 0, byte address fetched first after reset.
- IMEM_BYTES, 128, size of the legal byte-address space. A PC is legal only if pc < IMEM_BYTES.
- XLEN, 32, address and instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- read_address  out  XLEN  byte address to instruction memory; equals the pc register.
- instruction_in  in  XLEN  combinational instruction from memory for read_address.
- out_valid  out  1  output stage holds an instruction.
- out_ready  in  1  decode accepts this cycle; transfer occurs when out_valid & out_ready.
- out_instr  out  XLEN  registered instruction.
- out_pc  out  XLEN  byte address of out_instr.
- redirect_valid  in  1  execute requests a PC change.
- redirect_target  in  XLEN  new byte address.
- fault  out  1  sticky; set on illegal PC, cleared only by rst.
- fetch_count  out  XLEN  number of completed out transfers; wraps modulo 2^XLEN.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst has priority over every other input on any edge, including mid-handshake or mid-redirect.
- Reset values:
  - pc = RESET_PC, state = WARMUP.
  - out_valid = 0, out_instr = 0, out_pc = 0.
  - fault = 0, fetch_count = 0.
- States:
  - WARMUP: entered on reset. Memory contents become valid on the first non-reset edge. The unit issues no fetch in this state. Next state is RUN after exactly one non-reset cycle.
  - RUN: normal fetch.
  - HALT: no fetch, pc frozen, out_valid forced to 0. Exits only on rst.
- RUN, load condition: load = !out_valid | out_ready. When load is true and no redirect:
  - If pc is legal: out_instr <= instruction_in, out_pc <= pc, out_valid <= 1, pc <= pc + 4.
  - If pc is illegal: out_valid <= 0, fault <= 1, state <= HALT.
- RUN, no load (out_valid & !out_ready): out_instr, out_pc, out_valid and pc all hold. Output-stage contents never change while valid and not accepted.
- Redirect (RUN, redirect_valid = 1): takes priority over load.
  - out_valid <= 0; the pending instruction is flushed.
  - If target is legal: pc <= target.
  - If target[1:0] != 0 or target >= IMEM_BYTES: fault <= 1, state <= HALT, pc holds.
  - Redirect in WARMUP or HALT is ignored.
- Redirect with a simultaneous transfer: if out_valid & out_ready coincide with redirect_valid, the transfer still counts and fetch_count increments. The next cycle shows out_valid = 0.
- Throughput and latency:
  - Steady state is one instruction per cycle while out_ready stays 1.
  - First out_valid appears 2 edges after rst drops: WARMUP edge, then the first fetch edge.
  - After a legal redirect, the target instruction is valid 2 edges after the redirect edge: flush edge, then fetch edge.
- Arithmetic: pc + 4 is XLEN-bit and wraps. Legality is checked against the pc before fetch, so a sequential run off the end (pc = IMEM_BYTES) faults and does not fetch.
- fetch_count: increments on every out_valid & out_ready edge, in any state where out_valid = 1.

Decomposition:
- Shared package (core_pkg), holding:
  - fetch state enum: WARMUP, RUN, HALT.
  - XLEN, default RESET_PC, INSTR_BYTES = 4.
  - NOP encoding 32'h00000013.
- One natural sub-module: fetch_pc_next. It is combinational and computes the next pc and the legal/fault decision from pc, the redirect inputs and load. The FSM and output stage stay in the top module.

Test Plan:
- Reset, then out_ready = 1 constant, memory loaded with the standard program:
  - 2 edges after rst falls: out_valid = 1, out_pc = 0, out_instr = 0.
  - Next cycle: out_pc = 4, out_instr = 32'h019886B3.
  - out_pc increases by 4 each cycle.
- Backpressure: with out_pc = 8 valid, drop out_ready for 3 cycles.
  - out_instr and out_pc hold at 8; pc and read_address hold at 12; fetch_count does not change.
  - Raise out_ready: next cycle out_pc = 12.
- Branch at 44 (32'h00948663):
  - With out_pc = 44 valid and out_ready = 1, assert redirect_valid with target 56.
  - Next cycle: out_valid = 0. Following cycle: out_pc = 56.
  - fetch_count includes the 44 transfer.
- Misaligned redirect, target 0x22: fault = 1, out_valid = 0 and held, read_address frozen. rst then clears fault and restarts at RESET_PC.
- Run-off: sequential fetch reaches pc = 128 with IMEM_BYTES = 128.
  - The last delivered out_pc is 124.
  - Then fault = 1 and the unit is in HALT.
- rst asserted while out_valid = 1 & out_ready = 0 with redirect_valid = 1 on the same edge: all outputs return to reset values and the redirect is ignored.
